// File: rtl/centroid_div_sched.sv
// Centroid scheduler: shares one unsigned divider to turn per-frame pixel sums into a clamped (cx, cy).
// Define CENTROID_SCHED_TIMEOUT_EN to abort divider waits after TIMEOUT cycles.
module centroid_div_sched #(
   parameter int TIMEOUT = 64,
   parameter int X_MAX   = 1023,
   parameter int Y_MAX   = 767
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_done,
   input  logic [31:0] sum_x,
   input  logic [31:0] sum_y,
   input  logic [19:0] count,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_ready,
   input  logic [31:0] div_quotient,
   output logic [10:0] cx,
   output logic [9:0]  cy,
   output logic        valid,
   output logic        no_target,
   output logic        busy,
   output logic        overrun,
   output logic        timeout_err
);

   typedef enum logic [2:0] {IDLE, X_START, X_WAIT, Y_START, Y_WAIT, DONE} state_t;

   if (TIMEOUT < 1 || X_MAX < 0 || X_MAX > 2047 || Y_MAX < 0 || Y_MAX > 1023) begin : gBadParams
      $error("centroid_div_sched: parameter out of range");
   end

   state_t      state_q, state_d;
   logic [31:0] sumX_q, sumX_d;
   logic [31:0] sumY_q, sumY_d;
   logic [19:0] count_q, count_d;
   logic [10:0] xRes_q, xRes_d;
   logic [9:0]  yRes_q, yRes_d;
   logic [10:0] cx_q, cx_d;
   logic [9:0]  cy_q, cy_d;
   logic        valid_q, valid_d;
   logic        noTarget_q, noTarget_d;
   logic        overrun_q, overrun_d;
   logic        ready_q;
   logic        divDone;
   logic [10:0] xClamp;
   logic [9:0]  yClamp;

   // A wait only completes on a fresh rising edge of the divider's done level.
   assign divDone = div_ready & ~ready_q;

   // Clamp on the full quotient so large results never wrap into small ones.
   assign xClamp = (div_quotient > 32'(X_MAX)) ? 11'(X_MAX) : div_quotient[10:0];
   assign yClamp = (div_quotient > 32'(Y_MAX)) ? 10'(Y_MAX) : div_quotient[9:0];

`ifdef CENTROID_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
   logic             timeoutErr_q, timeoutErr_d;
   logic             waitExpired;

   assign waitExpired = (waitCnt_q == CNT_W'(TIMEOUT - 1));
   assign timeout_err = timeoutErr_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Next-state and datapath decisions for the two back-to-back divisions.
   always_comb begin
      state_d    = state_q;
      sumX_d     = sumX_q;
      sumY_d     = sumY_q;
      count_d    = count_q;
      xRes_d     = xRes_q;
      yRes_d     = yRes_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      valid_d    = 1'b0;
      noTarget_d = 1'b0;
      overrun_d  = frame_done && (state_q != IDLE);
`ifdef CENTROID_SCHED_TIMEOUT_EN
      waitCnt_d    = waitCnt_q;
      timeoutErr_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (frame_done) begin
               sumX_d  = sum_x;
               sumY_d  = sum_y;
               count_d = count;
               if (count != 20'd0) begin
                  state_d = X_START;
               end else begin
                  noTarget_d = 1'b1;
               end
            end
         end
         X_START: begin
            state_d = X_WAIT;
`ifdef CENTROID_SCHED_TIMEOUT_EN
            waitCnt_d = '0;
`endif
         end
         X_WAIT: begin
            if (divDone) begin
               xRes_d  = xClamp;
               state_d = Y_START;
            end
`ifdef CENTROID_SCHED_TIMEOUT_EN
            else if (waitExpired) begin
               timeoutErr_d = 1'b1;
               state_d      = IDLE;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
`endif
         end
         Y_START: begin
            state_d = Y_WAIT;
`ifdef CENTROID_SCHED_TIMEOUT_EN
            waitCnt_d = '0;
`endif
         end
         Y_WAIT: begin
            if (divDone) begin
               yRes_d  = yClamp;
               state_d = DONE;
            end
`ifdef CENTROID_SCHED_TIMEOUT_EN
            else if (waitExpired) begin
               timeoutErr_d = 1'b1;
               state_d      = IDLE;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            cx_d    = xRes_q;
            cy_d    = yRes_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset also discards any frame_done in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sumX_q     <= '0;
         sumY_q     <= '0;
         count_q    <= '0;
         xRes_q     <= '0;
         yRes_q     <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         valid_q    <= 1'b0;
         noTarget_q <= 1'b0;
         overrun_q  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sumX_q     <= sumX_d;
         sumY_q     <= sumY_d;
         count_q    <= count_d;
         xRes_q     <= xRes_d;
         yRes_q     <= yRes_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         valid_q    <= valid_d;
         noTarget_q <= noTarget_d;
         overrun_q  <= overrun_d;
         ready_q    <= div_ready;
      end
   end

`ifdef CENTROID_SCHED_TIMEOUT_EN
   // Wait-state watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCnt_q    <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         waitCnt_q    <= waitCnt_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end
`endif

   assign div_start    = (state_q == X_START) || (state_q == Y_START);
   assign div_dividend = ((state_q == Y_START) || (state_q == Y_WAIT)) ? sumY_q : sumX_q;
   assign div_divisor  = {12'b0, count_q};
   assign cx           = cx_q;
   assign cy           = cy_q;
   assign valid        = valid_q;
   assign no_target    = noTarget_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_centroid_div_sched.sv
// Bench for centroid_div_sched: table of frames with hand-computed centroids and latencies,
// plus hand-written overrun, timeout and mid-job reset sequences against a behavioural divider.
module tb_centroid_div_sched;

   logic        clk;
   logic        reset;
   logic        frame_done;
   logic [31:0] sum_x;
   logic [31:0] sum_y;
   logic [19:0] count;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_ready;
   logic [31:0] div_quotient;
   logic [10:0] cx;
   logic [9:0]  cy;
   logic        valid;
   logic        no_target;
   logic        busy;
   logic        overrun;
   logic        timeout_err;

   centroid_div_sched dut (
      .clk         (clk),
      .reset       (reset),
      .frame_done  (frame_done),
      .sum_x       (sum_x),
      .sum_y       (sum_y),
      .count       (count),
      .div_start   (div_start),
      .div_dividend(div_dividend),
      .div_divisor (div_divisor),
      .div_ready   (div_ready),
      .div_quotient(div_quotient),
      .cx          (cx),
      .cy          (cy),
      .valid       (valid),
      .no_target   (no_target),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int divLat;
   bit divHang;
   int stabErr;

   // Behavioural divider: ready drops after a start, rises divLat cycles later with the quotient.
   initial begin
      logic [31:0] dd;
      logic [31:0] dv;
      div_ready    = 1'b0;
      div_quotient = '0;
      stabErr      = 0;
      forever begin
         @(negedge clk);
         if (div_start) begin
            dd = div_dividend;
            dv = div_divisor;
            @(posedge clk);
            #1 div_ready = 1'b0;
            repeat (divLat) @(posedge clk);
            #1;
            if (busy && (div_dividend != dd || div_divisor != dv)) stabErr++;
            if (!divHang) begin
               div_quotient = (dv == 0) ? 32'hFFFF_FFFF : dd / dv;
               div_ready    = 1'b1;
            end
         end
      end
   end

   int total;
   int bad;
   int cyc, evCyc, ovrCyc;
   int startCnt, validCnt, ntCnt, toCnt;
   bit busySeen;
   logic [31:0] dd0, dd1, dv0;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clearStats();
      cyc = 0; evCyc = -1; ovrCyc = -1;
      startCnt = 0; validCnt = 0; ntCnt = 0; toCnt = 0;
      busySeen = 1'b0; dd0 = '0; dd1 = '0; dv0 = '0;
   endtask

   // One clock, then sample every output #1 after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (div_start) begin
         if (startCnt == 0) begin
            dd0 = div_dividend;
            dv0 = div_divisor;
         end else begin
            dd1 = div_dividend;
         end
         startCnt++;
      end
      validCnt += int'(valid);
      ntCnt    += int'(no_target);
      toCnt    += int'(timeout_err);
      if (busy) busySeen = 1'b1;
      if (overrun && ovrCyc < 0) ovrCyc = cyc;
      if ((valid || no_target || timeout_err) && evCyc < 0) evCyc = cyc;
   endtask

   // Pulse frame_done in cycle 0, optionally again in cycle ovrAt, then run until an event or limit.
   task automatic applyStimulus(input int sx, input int sy, input int cnt, input int lat,
                                input int ovrAt, input int limit);
      clearStats();
      divLat     = lat;
      sum_x      = sx;
      sum_y      = sy;
      count      = 20'(cnt);
      frame_done = 1'b1;
      step();
      while (cyc < limit && !(evCyc >= 0 && cyc >= evCyc + 3)) begin
         if (cyc == ovrAt) begin
            frame_done = 1'b1;
            sum_x = 32'd100; sum_y = 32'd100; count = 20'd1;
         end else begin
            frame_done = 1'b0;
            sum_x = sx; sum_y = sy; count = 20'(cnt);
         end
         step();
      end
      frame_done = 1'b0;
   endtask

   typedef struct {
      int sx, sy, cnt, lat;
      int expCx, expCy, expCyc;
      bit expNt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int stab0;
      total = 0; bad = 0;
      divLat = 1; divHang = 1'b0;

      vecs[0] = '{5000,  3000, 10, 34,  500,  300, 74, 1'b0};
      vecs[1] = '{0,     0,    0,  1,   500,  300, 1,  1'b1};
      vecs[2] = '{10230, 7670, 10, 1,   1023, 767, 8,  1'b0};
      vecs[3] = '{7,     5,    1,  3,   7,    5,   12, 1'b0};
      vecs[4] = '{10240, 7680, 10, 1,   1023, 767, 8,  1'b0};
      vecs[5] = '{12,    9,    4,  2,   3,    2,   10, 1'b0};
      vecs[6] = '{2053,  1029, 1,  1,   1023, 767, 8,  1'b0};
      vecs[7] = '{99,    99,   0,  1,   1023, 767, 1,  1'b1};

      reset = 1'b1; frame_done = 1'b0; sum_x = '0; sum_y = '0; count = '0;
      clearStats();
      repeat (3) step();
      checkOutput("reset cx", cx, 0);
      checkOutput("reset cy", cy, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset valid", valid, 0);
      checkOutput("reset div_start", div_start, 0);
      checkOutput("reset pulses", int'(no_target) + int'(overrun) + int'(timeout_err), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         stab0 = stabErr;
         applyStimulus(vecs[i].sx, vecs[i].sy, vecs[i].cnt, vecs[i].lat, -1, 300);
         checkOutput($sformatf("v%0d cx", i), cx, vecs[i].expCx);
         checkOutput($sformatf("v%0d cy", i), cy, vecs[i].expCy);
         checkOutput($sformatf("v%0d event cycle", i), evCyc, vecs[i].expCyc);
         checkOutput($sformatf("v%0d valid count", i), validCnt, vecs[i].expNt ? 0 : 1);
         checkOutput($sformatf("v%0d no_target count", i), ntCnt, vecs[i].expNt ? 1 : 0);
         checkOutput($sformatf("v%0d start count", i), startCnt, vecs[i].expNt ? 0 : 2);
         checkOutput($sformatf("v%0d busy seen", i), int'(busySeen), vecs[i].expNt ? 0 : 1);
         if (!vecs[i].expNt) begin
            checkOutput($sformatf("v%0d dividend x", i), int'(dd0), vecs[i].sx);
            checkOutput($sformatf("v%0d dividend y", i), int'(dd1), vecs[i].sy);
            checkOutput($sformatf("v%0d divisor", i), int'(dv0), vecs[i].cnt);
            checkOutput($sformatf("v%0d operands stable", i), stabErr - stab0, 0);
         end
      end

      // Second frame_done during X_WAIT: overrun pulse, first job finishes alone.
      applyStimulus(5000, 3000, 10, 10, 5, 300);
      checkOutput("ovr overrun cycle", ovrCyc, 6);
      checkOutput("ovr valid cycle", evCyc, 26);
      checkOutput("ovr valid count", validCnt, 1);
      checkOutput("ovr start count", startCnt, 2);
      checkOutput("ovr cx", cx, 500);
      checkOutput("ovr cy", cy, 300);

      // Divider never answers.
      divHang = 1'b1;
`ifdef CENTROID_SCHED_TIMEOUT_EN
      applyStimulus(6000, 6000, 10, 1, -1, 200);
      checkOutput("tmo event cycle", evCyc, 66);
      checkOutput("tmo pulse count", toCnt, 1);
      checkOutput("tmo busy after", busy, 0);
`else
      applyStimulus(6000, 6000, 10, 1, -1, 150);
      checkOutput("hang no event", evCyc, -1);
      checkOutput("hang busy held", busy, 1);
      checkOutput("hang timeout_err", toCnt, 0);
`endif
      checkOutput("hang valid count", validCnt, 0);
      checkOutput("hang start count", startCnt, 1);
      checkOutput("hang cx held", cx, 500);
      checkOutput("hang cy held", cy, 300);
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      divHang = 1'b0;
      step();

      applyStimulus(7, 5, 1, 3, -1, 300);
      checkOutput("pre-reset cx", cx, 7);

      // Reset in Y_WAIT (cycles 24..44 at latency 20), with frame_done coincident.
      clearStats();
      divLat = 20; sum_x = 32'd5000; sum_y = 32'd3000; count = 20'd10;
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      while (cyc < 30) step();
      reset = 1'b1; frame_done = 1'b1;
      step();
      reset = 1'b0; frame_done = 1'b0;
      checkOutput("rst busy", busy, 0);
      checkOutput("rst cx", cx, 0);
      checkOutput("rst cy", cy, 0);
      checkOutput("rst valid", valid, 0);
      checkOutput("rst div_start", div_start, 0);
      checkOutput("rst overrun", overrun, 0);
      validCnt = 0; startCnt = 0; busySeen = 1'b0;
      repeat (60) step();
      checkOutput("rst no valid after", validCnt, 0);
      checkOutput("rst no restart", startCnt, 0);
      checkOutput("rst stays idle", int'(busySeen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/centroid_div_sched.md
CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles in a wait state before abort.
REQ-002 Parameter X_MAX, default 1023: cx clamp limit.
REQ-003 Parameter Y_MAX, default 767: cy clamp limit.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 frame_done  in  1  one-cycle pulse: sums for the frame are final.
REQ-007 sum_x  in  32  accumulated x of white pixels.
REQ-008 sum_y  in  32  accumulated y of white pixels.
REQ-009 count  in  20  white-pixel count.
REQ-010 div_start  out  1  one-cycle start pulse to the shared unsigned divider.
REQ-011 div_dividend  out  32  dividend to the divider.
REQ-012 div_divisor  out  32  divisor to the divider, {12'b0, count snapshot}.
REQ-013 div_ready  in  1  divider done level.
REQ-014 div_quotient  in  32  divider quotient.
REQ-015 cx  out  11  centroid x.
REQ-016 cy  out  10  centroid y.
REQ-017 valid  out  1  one-cycle pulse: new cx/cy.
REQ-018 no_target  out  1  one-cycle pulse: frame had count==0.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 overrun  out  1  one-cycle pulse: frame_done dropped while busy.
REQ-021 timeout_err  out  1  one-cycle pulse: wait aborted.

Function
REQ-022 FSM states: IDLE, X_START, X_WAIT, Y_START, Y_WAIT, DONE.
REQ-023 IDLE + frame_done: snapshot sum_x, sum_y, count; count!=0 -> X_START; count==0 -> no_target pulse next cycle, cx/cy hold, stay IDLE.
REQ-024 X_START: div_start=1 for exactly this cycle, dividend=sum_x snapshot; -> X_WAIT.
REQ-025 Completion = div_ready high while div_ready registered one cycle earlier was low (rising edge); level-high ready alone never completes a wait.
REQ-026 X_WAIT completion: x result = min(div_quotient, X_MAX) latched internally; -> Y_START.
REQ-027 Y_START: div_start pulse, dividend=sum_y snapshot; -> Y_WAIT.
REQ-028 Y_WAIT completion: y result = min(div_quotient, Y_MAX); -> DONE.
REQ-029 DONE: cx, cy updated together, valid=1 this cycle; -> IDLE.
REQ-030 Clamp compares the full 32-bit quotient before truncation to 11/10 bits.
REQ-031 div_dividend/div_divisor held stable from start pulse through completion.
REQ-032 frame_done while busy: overrun pulse next cycle, request dropped, current job unaffected.
REQ-033 Latency, instant divider edge: valid exactly 6 cycles after frame_done plus both divider latencies.
REQ-034 cx/cy change only in DONE; no partial update on abort.

Reset
REQ-035 reset: state=IDLE, cx=0, cy=0, div_start=0, valid=0, no_target=0, overrun=0, timeout_err=0, busy=0, snapshots=0, wait counter=0.
REQ-036 reset mid-job aborts with no valid pulse; frame_done coincident with reset is ignored.

Configuration
REQ-037 Macro CENTROID_SCHED_TIMEOUT_EN defined: wait counter clears on entering X_WAIT/Y_WAIT; reaching TIMEOUT cycles without completion -> timeout_err pulse, -> IDLE, cx/cy hold.
REQ-038 Macro undefined: no counter; waits are unbounded; timeout_err tied 0.

Verification
REQ-039 sum_x=5000, sum_y=3000, count=10, divider 34 cycles -> two div_start pulses, cx=500, cy=300, single valid.
REQ-040 count=0 -> no div_start, no_target pulse, cx/cy unchanged, busy stays 0.
REQ-041 sum_x=20000, sum_y=9000, count=10 -> cx=1023, cy=767.
REQ-042 Second frame_done during X_WAIT -> overrun pulse; first job completes; exactly one valid.
REQ-043 TIMEOUT_EN, div_ready held low -> timeout_err 64 cycles after X_WAIT entry, IDLE, cx/cy unchanged; without macro -> busy stays high.
REQ-044 reset asserted during Y_WAIT -> next cycle IDLE, all outputs at reset values, no valid.
